ast_pattern_classifier: RTL and testbench

Store-and-forward Avalon-ST packet classifier, next generation of the lab C1 string-search block. It searches each incoming packet for a byte pattern programmed over Avalon-MM and buffers the whole packet internally. It then replays the packet on the source side with `ast_channel_o` set for every beat according to the match result. Width, pattern length, buffer depth and channel width are parametrised; pattern length, enable and match channel are runtime-programmable.

---
 rtl/ast_pattern_classifier.sv | 214 +++++++++++++++++++++
 tb/tb_ast_pattern_classifier.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ast_pattern_classifier.sv
// ast_pattern_classifier: store-and-forward Avalon-ST classifier that tags packets containing a CSR-programmed byte pattern
module ast_pattern_classifier #(
    parameter int AST_DWIDTH    = 64,
    parameter int AMM_DWIDTH    = 32,
    parameter int AMM_AWIDTH    = 3,
    parameter int STR_LEN       = 12,
    parameter int DEPTH         = 256,
    parameter int PKT_DEPTH     = 4,
    parameter int CHANNEL_WIDTH = 1,
    parameter int EMPTY_SIZE    = $clog2(AST_DWIDTH/8)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AMM_AWIDTH-1:0]    amm_address_i,
    input  logic                     amm_write_i,
    input  logic                     amm_read_i,
    input  logic [AMM_DWIDTH-1:0]    amm_writedata_i,
    output logic [AMM_DWIDTH-1:0]    amm_readdata_o,
    output logic                     amm_readdatavalid_o,
    input  logic [AST_DWIDTH-1:0]    ast_data_i,
    input  logic                     ast_valid_i,
    input  logic                     ast_startofpacket_i,
    input  logic                     ast_endofpacket_i,
    input  logic [EMPTY_SIZE-1:0]    ast_empty_i,
    output logic                     ast_ready_o,
    output logic [AST_DWIDTH-1:0]    ast_data_o,
    output logic                     ast_valid_o,
    output logic                     ast_startofpacket_o,
    output logic                     ast_endofpacket_o,
    output logic [EMPTY_SIZE-1:0]    ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
    input  logic                     ast_ready_i
);
    localparam int NB       = AST_DWIDTH/8;
    localparam int PAT_REGS = STR_LEN*8/AMM_DWIDTH;
    localparam int PW       = STR_LEN*8;
    localparam int AW       = $clog2(DEPTH);
    localparam int RW       = $clog2(PKT_DEPTH);
    localparam int WW       = AST_DWIDTH + 2 + EMPTY_SIZE;
    localparam int HW       = $clog2(STR_LEN + 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic                     ctrl_en, snap_en, eff_en;
    logic [7:0]               ctrl_len, snap_len, eff_len;
    logic [CHANNEL_WIDTH-1:0] ctrl_chan, snap_chan, eff_chan;
    logic [AMM_DWIDTH-1:0]    pat [PAT_REGS];
    logic [PW-1:0]            live_pat, snap_pat, eff_pat, pat_r;
    logic [31:0]              hits;
    logic                     hit_pulse, wr_ctrl, wr_hits;
    logic [AMM_DWIDTH-1:0]    rd_word;
    logic [PW-1:0]            hist;
    logic [HW-1:0]            hcnt;
    logic [PW+AST_DWIDTH-1:0] win;
    int                       base, nvalid;
    logic                     len_ok, ok, hit, match_r, match_now;
    logic                     acc, pop, ready_en, dfull, rfull;
    logic [WW-1:0]            mem [DEPTH];
    logic [AW-1:0]            wptr, rptr;
    logic [AW:0]              dcnt;
    logic [CHANNEL_WIDTH-1:0] rmem [PKT_DEPTH];
    logic [RW-1:0]            rwp, rrp;
    logic [RW:0]              rcnt;
    logic [WW-1:0]            head;
    logic                     head_eop;
    state_t                   state, state_nx;

    assign wr_ctrl     = amm_write_i && amm_address_i == '0;
    assign wr_hits     = amm_write_i && amm_address_i == AMM_AWIDTH'(PAT_REGS + 1);
    assign dfull       = dcnt == (AW+1)'(DEPTH);
    assign rfull       = rcnt == (RW+1)'(PKT_DEPTH);
    assign ast_ready_o = ready_en && !dfull && !rfull;
    assign acc         = ast_valid_i && ast_ready_o;
    assign head        = mem[rptr];
    assign head_eop    = head[EMPTY_SIZE];
    assign pop         = ast_valid_o && ast_ready_i;

    // CSR registers; a HITS write-clear takes priority over a pending increment
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            ctrl_en   <= 1'b0;
            ctrl_len  <= '0;
            ctrl_chan <= '0;
            hits      <= '0;
            for (int i = 0; i < PAT_REGS; i++) pat[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= amm_writedata_i[0];
                ctrl_len  <= amm_writedata_i[15:8];
                ctrl_chan <= amm_writedata_i[16 +: CHANNEL_WIDTH];
            end
            for (int i = 0; i < PAT_REGS; i++)
                if (amm_write_i && amm_address_i == AMM_AWIDTH'(i + 1)) pat[i] <= amm_writedata_i;
            if (wr_hits) hits <= '0;
            else if (hit_pulse && hits != '1) hits <= hits + 32'd1;
        end

    // CSR read mux and flattened live pattern (first byte in the MSB)
    always_comb begin
        rd_word  = '0;
        live_pat = '0;
        if (amm_address_i == '0) begin
            rd_word[0]                    = ctrl_en;
            rd_word[15:8]                 = ctrl_len;
            rd_word[16 +: CHANNEL_WIDTH]  = ctrl_chan;
        end
        if (amm_address_i == AMM_AWIDTH'(PAT_REGS + 1)) rd_word[31:0] = hits;
        for (int i = 0; i < PAT_REGS; i++) begin
            live_pat[(PAT_REGS-1-i)*AMM_DWIDTH +: AMM_DWIDTH] = pat[i];
            if (amm_address_i == AMM_AWIDTH'(i + 1)) rd_word = pat[i];
        end
    end

    // one-cycle read response, sampled before any same-cycle write lands
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            amm_readdata_o      <= '0;
            amm_readdatavalid_o <= 1'b0;
        end else begin
            amm_readdata_o      <= amm_read_i ? rd_word : '0;
            amm_readdatavalid_o <= amm_read_i;
        end

    // parallel match of every valid end position in the beat against the right-aligned pattern
    always_comb begin
        eff_en    = ast_startofpacket_i ? ctrl_en : snap_en;
        eff_len   = ast_startofpacket_i ? ctrl_len : snap_len;
        eff_chan  = ast_startofpacket_i ? ctrl_chan : snap_chan;
        eff_pat   = ast_startofpacket_i ? live_pat : snap_pat;
        len_ok    = eff_en && eff_len != 0 && int'(eff_len) <= STR_LEN;
        pat_r     = eff_pat >> (len_ok ? (STR_LEN - int'(eff_len)) * 8 : 0);
        win       = {hist, ast_data_i};
        base      = ast_startofpacket_i ? 0 : int'(hcnt);
        nvalid    = NB - (ast_endofpacket_i ? int'(ast_empty_i) : 0);
        hit       = 1'b0;
        ok        = 1'b0;
        for (int j = 0; j < NB; j++) begin
            ok = len_ok && j < nvalid && base + j + 1 >= int'(eff_len);
            for (int k = 0; k < STR_LEN; k++)
                if (k < int'(eff_len) && win[(NB-1-j+k)*8 +: 8] != pat_r[k*8 +: 8]) ok = 1'b0;
            hit = hit | ok;
        end
        match_now = (ast_startofpacket_i ? 1'b0 : match_r) | hit;
    end

    // per-packet snapshot, byte history window and sticky match flag
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            snap_en   <= 1'b0;
            snap_len  <= '0;
            snap_chan <= '0;
            snap_pat  <= '0;
            hist      <= '0;
            hcnt      <= '0;
            match_r   <= 1'b0;
            hit_pulse <= 1'b0;
        end else begin
            hit_pulse <= acc && ast_endofpacket_i && match_now;
            if (acc) begin
                hist    <= win[PW-1:0];
                hcnt    <= (base + NB >= STR_LEN) ? HW'(STR_LEN) : HW'(base + NB);
                match_r <= match_now;
                if (ast_startofpacket_i) begin
                    snap_en   <= ctrl_en;
                    snap_len  <= ctrl_len;
                    snap_chan <= ctrl_chan;
                    snap_pat  <= live_pat;
                end
            end
        end

    // buffer storage is not reset; pointers define what is valid
    always_ff @(posedge clk_i) begin
        if (acc) mem[wptr] <= {ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_empty_i};
        if (acc && ast_endofpacket_i) rmem[rwp] <= match_now ? eff_chan : '0;
    end

    // data and result buffer pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            ready_en <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            dcnt     <= '0;
            rwp      <= '0;
            rrp      <= '0;
            rcnt     <= '0;
        end else begin
            ready_en <= 1'b1;
            if (acc) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
            if (pop) rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
            dcnt <= dcnt + (AW+1)'(acc) - (AW+1)'(pop);
            if (acc && ast_endofpacket_i) rwp <= (rwp == RW'(PKT_DEPTH-1)) ? '0 : rwp + 1'b1;
            if (pop && head_eop) rrp <= (rrp == RW'(PKT_DEPTH-1)) ? '0 : rrp + 1'b1;
            rcnt <= rcnt + (RW+1)'(acc && ast_endofpacket_i) - (RW+1)'(pop && head_eop);
        end

    // output FSM state register
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_nx;

    // start a packet when a result is pending; leave after its EOP unless another is queued
    always_comb
        state_nx = (state == IDLE) ? (rcnt != 0 ? SEND : IDLE) :
                   (pop && head_eop && rcnt == 1) ? IDLE : SEND;

    // source outputs are forced to zero whenever not sending
    always_comb begin
        ast_valid_o = state == SEND;
        {ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o} = ast_valid_o ? head : '0;
        ast_channel_o = ast_valid_o ? rmem[rrp] : '0;
    end
endmodule

// File: tb/tb_ast_pattern_classifier.sv
// tb_ast_pattern_classifier: directed self-checking bench for the Avalon-ST pattern classifier
module tb_ast_pattern_classifier;
    localparam int NB = 8;
    localparam logic [95:0] PAT = "hello, world";

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic [2:0]  amm_address_i = '0;
    logic        amm_write_i = 1'b0, amm_read_i = 1'b0;
    logic [31:0] amm_writedata_i = '0, amm_readdata_o;
    logic        amm_readdatavalid_o;
    logic [63:0] ast_data_i = '0, ast_data_o;
    logic        ast_valid_i = 1'b0, ast_startofpacket_i = 1'b0, ast_endofpacket_i = 1'b0;
    logic [2:0]  ast_empty_i = '0, ast_empty_o;
    logic        ast_ready_o, ast_valid_o, ast_startofpacket_o, ast_endofpacket_o;
    logic [0:0]  ast_channel_o;
    logic        ast_ready_i = 1'b1;

    int          tests = 0, fails = 0, rdy_mode = 0;
    logic [7:0]  pkt [2048];
    logic [69:0] exp_q [$];
    logic [31:0] rd;

    ast_pattern_classifier dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .amm_address_i(amm_address_i), .amm_write_i(amm_write_i), .amm_read_i(amm_read_i),
        .amm_writedata_i(amm_writedata_i), .amm_readdata_o(amm_readdata_o),
        .amm_readdatavalid_o(amm_readdatavalid_o),
        .ast_data_i(ast_data_i), .ast_valid_i(ast_valid_i), .ast_startofpacket_i(ast_startofpacket_i),
        .ast_endofpacket_i(ast_endofpacket_i), .ast_empty_i(ast_empty_i), .ast_ready_o(ast_ready_o),
        .ast_data_o(ast_data_o), .ast_valid_o(ast_valid_o), .ast_startofpacket_o(ast_startofpacket_o),
        .ast_endofpacket_o(ast_endofpacket_o), .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o),
        .ast_ready_i(ast_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        ast_ready_i = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic chk(input string tag, input logic ok);
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $error("FAIL %s", tag);
        end
    endtask

    always @(negedge clk_i) begin
        logic [69:0] e;
        if (!rst_i && ast_valid_o && ast_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected beat", ast_valid_o === 1'b0);
            else begin
                e = exp_q.pop_front();
                chk("out beat", {ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o} === e);
            end
        end
    end

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        amm_address_i = a;
        amm_writedata_i = d;
        amm_write_i = 1'b1;
        @(posedge clk_i);
        #1;
        amm_write_i = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        amm_address_i = a;
        amm_read_i = 1'b1;
        @(posedge clk_i);
        #1;
        amm_read_i = 1'b0;
        chk("readdatavalid", amm_readdatavalid_o === 1'b1);
        d = amm_readdata_o;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n + NB; i++) pkt[i] = 8'(i);
    endtask

    task automatic put(input int off, input logic [95:0] s, input int first, input int cnt);
        for (int i = 0; i < cnt; i++) pkt[off + i] = s[(11 - first - i) * 8 +: 8];
    endtask

    task automatic send(input int n, input logic ch, input int wr_beat = -1, input logic [31:0] wr_val = '0);
        int nb;
        nb = (n + NB - 1) / NB;
        for (int b = 0; b < nb; b++) begin
            logic [63:0] d;
            int t;
            t = 0;
            for (int i = 0; i < NB; i++) d[(NB-1-i)*8 +: 8] = pkt[b*NB + i];
            ast_data_i = d;
            ast_valid_i = 1'b1;
            ast_startofpacket_i = b == 0;
            ast_endofpacket_i = b == nb - 1;
            ast_empty_i = (b == nb - 1) ? 3'(nb * NB - n) : 3'd0;
            if (b == wr_beat) begin
                amm_address_i = '0;
                amm_writedata_i = wr_val;
                amm_write_i = 1'b1;
            end
            while (!ast_ready_o && t < 5000) begin
                @(posedge clk_i);
                #1;
                t++;
            end
            if (t == 5000) chk("sink ready timeout", ast_ready_o === 1'b1);
            exp_q.push_back({d, ast_startofpacket_i, ast_endofpacket_i, ast_empty_i, ch});
            @(posedge clk_i);
            #1;
            amm_write_i = 1'b0;
        end
        ast_valid_i = 1'b0;
        ast_startofpacket_i = 1'b0;
        ast_endofpacket_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        chk("drain remaining beats", exp_q.size() === 0);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("ready in reset", ast_ready_o === 1'b0);
        chk("valid in reset", ast_valid_o === 1'b0);
        rst_i = 1'b0;
        chk("ready at release", ast_ready_o === 1'b0);
        @(posedge clk_i);
        #1;
        chk("ready after release", ast_ready_o === 1'b1);
        csr_read(3'd0, rd);
        chk("ctrl reset", rd === 32'h0);
        csr_read(3'd4, rd);
        chk("hits reset", rd === 32'h0);
        @(posedge clk_i);
        #1;
        chk("readdatavalid pulse", amm_readdatavalid_o === 1'b0);

        csr_write(3'd1, "hell");
        csr_write(3'd2, "o, w");
        csr_write(3'd3, "orld");
        amm_address_i = 3'd0;
        amm_writedata_i = 32'h0001_0C01;
        amm_write_i = 1'b1;
        amm_read_i = 1'b1;
        @(posedge clk_i);
        #1;
        amm_write_i = 1'b0;
        amm_read_i = 1'b0;
        chk("read during write old value", amm_readdata_o === 32'h0);
        csr_read(3'd0, rd);
        chk("ctrl readback", rd === 32'h0001_0C01);
        csr_read(3'd2, rd);
        chk("pattern reg2", rd === 32'h6f2c_2077);
        csr_write(3'd5, 32'hdead_beef);
        csr_read(3'd5, rd);
        chk("unmapped reads zero", rd === 32'h0);

        fill(60);
        put(5, PAT, 0, 12);
        send(60, 1'b1);
        drain();
        csr_read(3'd4, rd);
        chk("hits after match", rd === 32'd1);

        fill(60);
        put(54, PAT, 0, 6);
        send(60, 1'b0);
        fill(60);
        put(0, PAT, 6, 6);
        send(60, 1'b0);
        drain();
        csr_read(3'd4, rd);
        chk("hits after split", rd === 32'd1);

        fill(61);
        put(52, PAT, 0, 12);
        send(61, 1'b0);
        fill(61);
        put(49, PAT, 0, 12);
        send(61, 1'b1);
        drain();
        csr_read(3'd4, rd);
        chk("hits after empty tests", rd === 32'd2);

        csr_write(3'd0, 32'h0001_0D01);
        fill(60);
        put(5, PAT, 0, 12);
        send(60, 1'b0);
        drain();
        csr_read(3'd4, rd);
        chk("hits with L over max", rd === 32'd2);
        csr_write(3'd0, 32'h0001_0C01);

        fill(60);
        put(5, PAT, 0, 12);
        send(60, 1'b1);
        csr_write(3'd4, 32'h0);
        csr_read(3'd4, rd);
        chk("clear beats increment", rd === 32'd0);
        drain();

        rdy_mode = 1;
        fill(1514);
        send(1514, 1'b0);
        drain();
        rdy_mode = 2;
        for (int p = 0; p < 4; p++) begin
            if (p == 3) chk("ready with 3 pending", ast_ready_o === 1'b1);
            fill(60);
            send(60, 1'b0);
        end
        chk("ready low with 4 pending", ast_ready_o === 1'b0);
        chk("output held while stalled", ast_valid_o === 1'b1);
        chk("sop held while stalled", ast_startofpacket_o === 1'b1);
        rdy_mode = 0;
        fill(60);
        send(60, 1'b0);
        drain();

        fill(60);
        put(5, PAT, 0, 12);
        send(60, 1'b1, 1, 32'h0);
        drain();
        csr_read(3'd4, rd);
        chk("hits old settings", rd === 32'd1);
        fill(60);
        put(5, PAT, 0, 12);
        send(60, 1'b0);
        drain();
        csr_read(3'd4, rd);
        chk("hits after disable", rd === 32'd1);

        csr_write(3'd0, 32'h0001_0C01);
        rdy_mode = 2;
        fill(60);
        put(5, PAT, 0, 12);
        send(60, 1'b1);
        for (int t = 0; t < 20 && !ast_valid_o; t++) begin
            @(posedge clk_i);
            #1;
        end
        chk("valid before reset", ast_valid_o === 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("valid async reset", ast_valid_o === 1'b0);
        chk("data async reset", ast_data_o === 64'h0);
        chk("channel async reset", ast_channel_o === 1'b0);
        exp_q.delete();
        rdy_mode = 0;
        @(posedge clk_i);
        #1;
        chk("ready in second reset", ast_ready_o === 1'b0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        csr_read(3'd4, rd);
        chk("hits after reset", rd === 32'h0);
        csr_read(3'd0, rd);
        chk("ctrl after reset", rd === 32'h0);
        csr_read(3'd1, rd);
        chk("pattern after reset", rd === 32'h0);
        fill(60);
        put(5, PAT, 0, 12);
        send(60, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
